// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester round-robin arbiter and sequencer in front of a single-port
//   memory. It accepts one request at a time, issues exactly one memory
//   command for it, and returns read data with a one-cycle valid pulse.
//
// Parameters
//   ADDR_WIDTH   memory address width
//   DATA_WIDTH   memory data width
//   READ_LATENCY cycles from mem_read asserted to mem_rdata valid (1..4)
//
// Ports
//   clk, rst_                      clock (posedge), synchronous active-low reset
//   req0/we0/addr0/wdata0          requester 0 command; req held until gnt0
//   gnt0, rvalid0                  requester 0 grant / read-valid pulses
//   req1/we1/addr1/wdata1          requester 1 command; req held until gnt1
//   gnt1, rvalid1                  requester 1 grant / read-valid pulses
//   rdata                          shared read data, qualified by rvalid0/1
//   busy                           high whenever the sequencer is not idle
//   mem_read, mem_write            memory strobes (never both high)
//   mem_addr, mem_wdata            memory address / write data (held when idle)
//   mem_rdata                      memory read data
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(READ_LATENCY) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    logic             ptr;      // requester that wins a tie
    logic             win;      // requester owning the current transaction
    logic             cmd_we;
    logic [CNT_W-1:0] cnt;

    logic                  sel1;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    always_comb begin
        sel1      = (req0 && req1) ? ptr : req1;
        sel_we    = sel1 ? we1    : we0;
        sel_addr  = sel1 ? addr1  : addr0;
        sel_wdata = sel1 ? wdata1 : wdata0;
    end

    // The latched command is loaded straight into mem_addr/mem_wdata on the
    // IDLE->ISSUE edge so the strobes and grant appear registered during ISSUE.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            win       <= 1'b0;
            cmd_we    <= 1'b0;
            cnt       <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        win       <= sel1;
                        cmd_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_write <= sel_we;
                        mem_read  <= ~sel_we;
                        gnt0      <= ~sel1;
                        gnt1      <= sel1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    ptr <= ~win;
                    if (cmd_we) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt   <= CNT_W'(READ_LATENCY - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rdata   <= mem_rdata;
                        rvalid0 <= ~win;
                        rvalid1 <= win;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Two arbiter instances (read latency 1 and 3), each with its own memory
//   model and two requester agents. A transaction-level reference model
//   predicts every output every cycle from the arbitration and occupancy rules.
module tb_mem_arbiter;

    localparam int AW  = 5;
    localparam int DW  = 8;
    localparam int RL0 = 1;
    localparam int RL1 = 3;
    localparam int QD  = 128;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [7:0]    gap;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance k uses requester slots 2k and 2k+1
    logic          rst_d    [2];
    logic          req_d    [4];
    logic          we_d     [4];
    logic [AW-1:0] addr_d   [4];
    logic [DW-1:0] wdata_d  [4];
    logic          gnt_o    [4];
    logic          rvalid_o [4];
    logic [DW-1:0] rdata_o  [2];
    logic          busy_o   [2];
    logic          mrd_o    [2];
    logic          mwr_o    [2];
    logic [AW-1:0] maddr_o  [2];
    logic [DW-1:0] mwdata_o [2];
    logic [DW-1:0] mrdata_d [2];

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL0)) u_dut0 (
        .clk(clk), .rst_(rst_d[0]),
        .req0(req_d[0]), .we0(we_d[0]), .addr0(addr_d[0]), .wdata0(wdata_d[0]),
        .gnt0(gnt_o[0]), .rvalid0(rvalid_o[0]),
        .req1(req_d[1]), .we1(we_d[1]), .addr1(addr_d[1]), .wdata1(wdata_d[1]),
        .gnt1(gnt_o[1]), .rvalid1(rvalid_o[1]),
        .rdata(rdata_o[0]), .busy(busy_o[0]),
        .mem_read(mrd_o[0]), .mem_write(mwr_o[0]),
        .mem_addr(maddr_o[0]), .mem_wdata(mwdata_o[0]), .mem_rdata(mrdata_d[0])
    );

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL1)) u_dut1 (
        .clk(clk), .rst_(rst_d[1]),
        .req0(req_d[2]), .we0(we_d[2]), .addr0(addr_d[2]), .wdata0(wdata_d[2]),
        .gnt0(gnt_o[2]), .rvalid0(rvalid_o[2]),
        .req1(req_d[3]), .we1(we_d[3]), .addr1(addr_d[3]), .wdata1(wdata_d[3]),
        .gnt1(gnt_o[3]), .rvalid1(rvalid_o[3]),
        .rdata(rdata_o[1]), .busy(busy_o[1]),
        .mem_read(mrd_o[1]), .mem_write(mwr_o[1]),
        .mem_addr(maddr_o[1]), .mem_wdata(mwdata_o[1]), .mem_rdata(mrdata_d[1])
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int rl(input int k);
        return (k == 0) ? RL0 : RL1;
    endfunction

    function automatic logic [DW-1:0] init_val(input int k, input int a);
        return DW'(a * 37 + k * 11 + 3);
    endfunction

    // ---------------- memory models (environment) ----------------
    logic [DW-1:0] tmem  [2][32];
    logic [DW-1:0] pdata [2];
    int            pcnt  [2];

    // Read data is presented for exactly one cycle; junk otherwise.
    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 32; a++) tmem[k][a] = init_val(k, a);
            pcnt[k]     = 0;
            pdata[k]    = '0;
            mrdata_d[k] = '0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (mwr_o[k] === 1'b1) tmem[k][maddr_o[k]] = mwdata_o[k];
                if (mrd_o[k] === 1'b1) begin
                    pdata[k] = tmem[k][maddr_o[k]];
                    pcnt[k]  = rl(k);
                end
                if (pcnt[k] == 1) mrdata_d[k] <= pdata[k];
                else              mrdata_d[k] <= DW'($urandom);
                if (pcnt[k] > 0) pcnt[k]--;
            end
        end
    end

    // ---------------- reference model + agents ----------------
    int            e_cnt;
    logic          m_ptr   [2];
    int            m_ns    [2];   // next edge at which the arbiter samples requests
    int            m_iss   [2];   // edge at which the current command was accepted
    logic          m_iss_v [2];
    logic          m_we    [2];
    logic          m_win   [2];
    logic [AW-1:0] m_ma    [2];
    logic [DW-1:0] m_mw    [2];
    logic [DW-1:0] m_rd    [2];
    logic [DW-1:0] m_rdexp [2];
    logic [DW-1:0] ref_mem [2][32];
    logic          granted [4];

    txn_t        fifo     [4][QD];
    int unsigned hd       [4];
    int unsigned tl       [4];
    logic        active   [4];
    logic        pop_pend [4];
    int          gapc     [4];

    int last_g0 [2];
    int rd_edge [2];
    int lat_min [2];
    int lat_max [2];

    function automatic void model_step(input int k);
        int   j;
        logic w;
        granted[2*k]   = 1'b0;
        granted[2*k+1] = 1'b0;
        if (rst_d[k] !== 1'b1) begin
            m_ptr[k]   = 1'b0;
            m_ns[k]    = e_cnt + 1;
            m_iss_v[k] = 1'b0;
            m_ma[k]    = '0;
            m_mw[k]    = '0;
            m_rd[k]    = '0;
        end else begin
            if (e_cnt == m_ns[k]) begin
                if (req_d[2*k] || req_d[2*k+1]) begin
                    w          = (req_d[2*k] && req_d[2*k+1]) ? m_ptr[k] : req_d[2*k+1];
                    j          = 2*k + int'(w);
                    m_win[k]   = w;
                    m_we[k]    = we_d[j];
                    m_iss[k]   = e_cnt;
                    m_iss_v[k] = 1'b1;
                    m_ptr[k]   = ~w;
                    m_ma[k]    = addr_d[j];
                    m_mw[k]    = wdata_d[j];
                    if (we_d[j]) begin
                        ref_mem[k][addr_d[j]] = wdata_d[j];
                        m_ns[k] = e_cnt + 2;
                    end else begin
                        m_rdexp[k] = ref_mem[k][addr_d[j]];
                        m_ns[k]    = e_cnt + 3 + rl(k);
                    end
                    granted[j] = 1'b1;
                end else begin
                    m_ns[k] = e_cnt + 1;
                end
            end
            if (m_iss_v[k] && !m_we[k] && e_cnt == m_iss[k] + 1 + rl(k)) m_rd[k] = m_rdexp[k];
        end
    endfunction

    task automatic compare(input int k);
        logic       strobe, rv, bz;
        logic [6:0] exp_ctl, obs_ctl;
        strobe  = m_iss_v[k] && (e_cnt == m_iss[k]);
        rv      = m_iss_v[k] && !m_we[k] && (e_cnt == m_iss[k] + 1 + rl(k));
        bz      = (e_cnt < m_ns[k] - 1);
        exp_ctl = {strobe && !m_win[k], strobe && m_win[k], rv && !m_win[k], rv && m_win[k],
                   strobe && !m_we[k], strobe && m_we[k], bz};
        obs_ctl = {gnt_o[2*k], gnt_o[2*k+1], rvalid_o[2*k], rvalid_o[2*k+1],
                   mrd_o[k], mwr_o[k], busy_o[k]};
        check($sformatf("u%0d ctl{g0,g1,rv0,rv1,rd,wr,busy} e%0d", k, e_cnt), 32'(obs_ctl), 32'(exp_ctl));
        check($sformatf("u%0d mem_addr e%0d", k, e_cnt), 32'(maddr_o[k]), 32'(m_ma[k]));
        check($sformatf("u%0d mem_wdata e%0d", k, e_cnt), 32'(mwdata_o[k]), 32'(m_mw[k]));
        check($sformatf("u%0d rdata e%0d", k, e_cnt), 32'(rdata_o[k]), 32'(m_rd[k]));
    endtask

    function automatic void agent_step(input int j);
        txn_t h;
        if (pop_pend[j]) begin
            hd[j]++;
            pop_pend[j] = 1'b0;
            active[j]   = 1'b0;
            gapc[j]     = 0;
        end
        if (granted[j]) pop_pend[j] = 1'b1;
        if (!active[j] && !pop_pend[j] && hd[j] != tl[j]) begin
            h = fifo[j][hd[j] % QD];
            if (gapc[j] >= int'(h.gap)) begin
                active[j] = 1'b1;
                gapc[j]   = 0;
            end else begin
                gapc[j]++;
            end
        end
        if (active[j]) begin
            h          = fifo[j][hd[j] % QD];
            req_d[j]   = 1'b1;
            we_d[j]    = h.we;
            addr_d[j]  = h.addr;
            wdata_d[j] = h.data;
        end else begin
            req_d[j]   = 1'b0;
            we_d[j]    = 1'($urandom);
            addr_d[j]  = AW'($urandom);
            wdata_d[j] = DW'($urandom);
        end
    endfunction

    initial begin
        e_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 1'b0; m_ns[k] = 1; m_iss[k] = 0; m_iss_v[k] = 1'b0;
            m_we[k] = 1'b0; m_win[k] = 1'b0; m_ma[k] = '0; m_mw[k] = '0;
            m_rd[k] = '0; m_rdexp[k] = '0;
            last_g0[k] = 0; rd_edge[k] = 0; lat_min[k] = 999; lat_max[k] = 0;
            for (int a = 0; a < 32; a++) ref_mem[k][a] = init_val(k, a);
        end
        for (int j = 0; j < 4; j++) begin
            hd[j] = 0; active[j] = 1'b0; pop_pend[j] = 1'b0; gapc[j] = 0; granted[j] = 1'b0;
            req_d[j] = 1'b0; we_d[j] = 1'b0; addr_d[j] = '0; wdata_d[j] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            e_cnt++;
            for (int k = 0; k < 2; k++) model_step(k);
            for (int k = 0; k < 2; k++) compare(k);
            for (int k = 0; k < 2; k++) begin
                if (gnt_o[2*k] === 1'b1) last_g0[k] = e_cnt;
                if (mrd_o[k] === 1'b1) rd_edge[k] = e_cnt;
                if (rvalid_o[2*k] === 1'b1 || rvalid_o[2*k+1] === 1'b1) begin
                    if (e_cnt - rd_edge[k] < lat_min[k]) lat_min[k] = e_cnt - rd_edge[k];
                    if (e_cnt - rd_edge[k] > lat_max[k]) lat_max[k] = e_cnt - rd_edge[k];
                end
            end
            for (int j = 0; j < 4; j++) agent_step(j);
        end
    end

    // ---------------- stimulus ----------------
    task automatic push(input int j, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int gap);
        fifo[j][tl[j] % QD] = '{we: we, addr: a, data: d, gap: 8'(gap)};
        tl[j]++;
    endtask

    function automatic logic is_idle(input int k);
        return (hd[2*k] == tl[2*k]) && (hd[2*k+1] == tl[2*k+1]) &&
               !active[2*k] && !active[2*k+1] && !pop_pend[2*k] && !pop_pend[2*k+1] &&
               (e_cnt >= m_ns[k] - 1);
    endfunction

    task automatic drain(input int k, input int budget, input logic rand_rst);
        int n = 0;
        while (!is_idle(k) && n < budget) begin
            @(negedge clk);
            rst_d[k] = rand_rst ? ($urandom_range(0, 99) != 0) : 1'b1;
            n++;
        end
        @(negedge clk);
        rst_d[k] = 1'b1;
        check($sformatf("u%0d drained", k), 32'(is_idle(k)), 32'd1);
    endtask

    task automatic sweep(input int k);
        int s;
        @(negedge clk);
        s = e_cnt + 2;
        for (int a = 0; a < 32; a++) push(2*k, 1'b1, AW'(a), DW'(a) ^ 8'hA5, 0);
        drain(k, 400, 1'b0);
        check($sformatf("u%0d sweep write cycles", k), 32'(last_g0[k] - s + 2), 32'd64);
        for (int a = 0; a < 32; a++) push(2*k+1, 1'b0, AW'(a), DW'($urandom), 0);
        drain(k, 600, 1'b0);
    endtask

    initial begin
        int  n;
        logic hit;
        rst_d[0] = 1'b0;
        rst_d[1] = 1'b0;
        for (int j = 0; j < 4; j++) tl[j] = 0;

        // both requesters waiting through reset; writes on 0, dependent reads on 1
        push(0, 1'b1, 5'h0A, 8'h5A, 0);
        push(0, 1'b1, 5'h03, 8'h33, 0);
        push(0, 1'b1, 5'h07, 8'h77, 0);
        push(1, 1'b0, 5'h0A, 8'h00, 0);
        push(1, 1'b0, 5'h03, 8'h00, 0);
        push(1, 1'b0, 5'h07, 8'h00, 0);
        repeat (3) @(negedge clk);
        rst_d[0] = 1'b1;
        rst_d[1] = 1'b1;
        drain(0, 200, 1'b0);

        // reset while a read is waiting on memory
        push(1, 1'b0, 5'h0A, 8'h00, 0);
        hit = 1'b0;
        n = 0;
        while (!hit && n < 50) begin
            @(negedge clk);
            n++;
            hit = m_iss_v[0] && !m_we[0] && (e_cnt > m_iss[0]) && (e_cnt <= m_iss[0] + RL0);
        end
        check("reset during WAIT reached", 32'(hit), 32'd1);
        rst_d[0] = 1'b0;
        @(negedge clk);
        rst_d[0] = 1'b1;
        push(0, 1'b1, 5'h01, 8'h11, 0);
        push(1, 1'b0, 5'h01, 8'h00, 0);
        drain(0, 100, 1'b0);

        sweep(0);
        sweep(1);

        // randomized traffic with occasional resets on both instances
        for (int b = 0; b < 8; b++) begin
            for (int j = 0; j < 4; j++) begin
                n = $urandom_range(1, 12);
                for (int t = 0; t < n; t++)
                    push(j, 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom), $urandom_range(0, 3));
            end
            drain(0, 800, 1'b1);
            drain(1, 800, 1'b1);
        end

        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d min read latency", k), 32'(lat_min[k]), 32'(rl(k) + 1));
            check($sformatf("u%0d max read latency", k), 32'(lat_max[k]), 32'(rl(k) + 1));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer that shares the single-port lab memory (read/write strobes, 5-bit address, 8-bit data, registered read data) between two bus masters.
- Sits between the requesters (test drivers or DMA-style agents) and the mem instance.
- Latches one request at a time, issues exactly one memory command, and returns read data with a valid pulse.
- Round-robin fairness between the two requesters.

Parameters:
- ADDR_WIDTH, 5, memory address width
- DATA_WIDTH, 8, memory data width
- READ_LATENCY, 1, cycles from mem_read asserted to mem_rdata valid (legal 1..4)

Ports:
- clk  in  1  clock, all logic on posedge
- rst_  in  1  synchronous active-low reset
- req0  in  1  requester 0 request; held high until gnt0 seen
- we0  in  1  requester 0 write (1) / read (0)
- addr0  in  ADDR_WIDTH  requester 0 address
- wdata0  in  DATA_WIDTH  requester 0 write data
- gnt0  out  1  one-cycle grant pulse to requester 0
- rvalid0  out  1  one-cycle read-data-valid pulse to requester 0
- req1, we1, addr1, wdata1, gnt1, rvalid1  same as above, for requester 1
- rdata  out  DATA_WIDTH  read data, shared; qualified by rvalid0/rvalid1
- busy  out  1  high whenever state != IDLE
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- Clock port is clk. Reset port is rst_: synchronous, active-low. All outputs are registered.
- Reset: state=IDLE; ptr=0 (requester 0 has priority); every output 0 (gnt*, rvalid*, rdata, busy, mem_read, mem_write, mem_addr, mem_wdata).
- A reset asserted in any state aborts the transaction: no gnt/rvalid afterwards, no memory strobe in the following cycle.
- FSM: IDLE -> ISSUE -> (WAIT -> RESP) for reads; IDLE -> ISSUE -> IDLE for writes.
- IDLE, arbitration:
  - only one req high: it wins.
  - both high: the requester indexed by ptr wins.
  - winner's we/addr/wdata latched into cmd registers; go to ISSUE.
  - no req: stay in IDLE.
- ISSUE (1 cycle):
  - drive mem_addr/mem_wdata from latched cmd; mem_write=we, mem_read=!we.
  - gnt of winner=1; ptr <= other requester.
  - write: next state IDLE. Read: next state WAIT, latency counter=READ_LATENCY-1.
- WAIT: strobes 0; count down; at 0 go to RESP (count 0 on entry means exactly one WAIT cycle). mem_rdata is sampled on the WAIT->RESP edge.
- RESP (1 cycle): rdata=sampled mem_rdata; rvalid of winner=1; next IDLE. rdata holds its value until the next read response.
- Read latency: req seen in IDLE at edge N -> mem_read high cycle N+1 -> rvalid high cycle N+2+READ_LATENCY.
- Throughput:
  - write occupancy 2 cycles (IDLE+ISSUE).
  - read occupancy 3+READ_LATENCY cycles.
- Requester rules:
  - inputs are ignored outside IDLE; changes after latching do not affect the issued command.
  - requester drops req (or presents a new request) on the edge where it samples gnt high.
  - a req held after gnt is treated as a new request.
- mem_addr/mem_wdata hold their last values when strobes are low. mem_read and mem_write are never both high.

Test Plan:
- Reset: assert rst_=0 for 3 cycles with req0=req1=1 -> all outputs 0 throughout; after release req0 wins first.
- Single write: req0=1, we0=1, addr0=5'h0A, wdata0=8'h5A -> next cycle mem_write=1, mem_addr=0A, mem_wdata=5A, gnt0=1; busy low the cycle after.
- Single read after write: req1=1, we1=0, addr1=5'h0A -> mem_read=1 + gnt1=1 one cycle after req sampled; rvalid1=1 with rdata=8'h5A two cycles later (READ_LATENCY=1); rvalid0 stays 0.
- Contention: both reqs held continuously from reset (req0 writes, req1 reads) -> grant order 0,1,0,1; no requester granted twice in a row; no two strobes in the same cycle.
- Reset mid-read: rst_=0 during WAIT -> no rvalid1, state IDLE, ptr=0, outputs 0 on the next cycle.
- Sweep: req0 writes addr 0..31 with data addr^8'hA5, then req1 reads 0..31 -> every rdata matches; write phase completes in 64 cycles; repeat with READ_LATENCY=3 -> rvalid 4 cycles after mem_read.
